sdram_iq_buffer: RTL

Elastic SDRAM-backed ring buffer for 24-bit IQ pairs, acting as the master of the sdram_controller Avalon-style slave port (az_*/za_*). It sits between the AFE-to-FT600 path and the FT600 FSM, absorbing USB stalls far beyond the on-chip a2f_fifo depth. Each IQ pair occupies two consecutive 16-bit SDRAM words.

---
 rtl/sdram_pkg.sv | 23 ++
 rtl/sdram_iq_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: bus geometry and the IQ buffer FSM encoding.
package sdram_pkg;

    localparam int SDRAM_BA_W  = 2;
    localparam int SDRAM_ROW_W = 11;
    localparam int SDRAM_COL_W = 8;
    localparam int SDRAM_DQ_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LO,
        ST_WR_HI,
        ST_RD_LO,
        ST_RD_HI,
        ST_RD_WAIT
    } state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_iq_buffer.sv
// SDRAM-backed elastic ring buffer for IQ pairs; each pair is stored as two
// consecutive 16-bit words and the master alternates write/read grants.
module sdram_iq_buffer
    import sdram_pkg::*;
#(
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int AZ_ADDR_WIDTH = SDRAM_BA_W + SDRAM_ROW_W + SDRAM_COL_W
) (
    input  logic                     clk_main,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [IQ_PAIR_WIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [IQ_PAIR_WIDTH-1:0] out_data,
    input  logic                     out_ready,
    output logic [AZ_ADDR_WIDTH-1:0] az_addr,
    output logic [1:0]               az_be_n,
    output logic                     az_cs,
    output logic                     az_rd_n,
    output logic                     az_wr_n,
    output logic [SDRAM_DQ_W-1:0]    az_data,
    input  logic [SDRAM_DQ_W-1:0]    za_data,
    input  logic                     za_valid,
    input  logic                     za_waitrequest,
    output logic [AZ_ADDR_WIDTH-1:0] level
);

    localparam int PTR_W       = AZ_ADDR_WIDTH - 1;
    localparam int DEPTH_PAIRS = 2 ** PTR_W;
    localparam int HI_W        = IQ_PAIR_WIDTH - SDRAM_DQ_W;
    localparam logic [AZ_ADDR_WIDTH-1:0] LEVEL_FULL = AZ_ADDR_WIDTH'(DEPTH_PAIRS);

    state_e                     state_q;
    grant_e                     last_grant_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [AZ_ADDR_WIDTH-1:0]   level_q;
    logic [1:0]                 rsp_cnt_q;
    logic [SDRAM_DQ_W-1:0]      wr_hi_q;
    logic                       out_valid_q;
    logic [IQ_PAIR_WIDTH-1:0]   out_data_q;
    logic                       az_cs_q;
    logic                       az_rd_n_q;
    logic                       az_wr_n_q;
    logic [1:0]                 az_be_n_q;
    logic [AZ_ADDR_WIDTH-1:0]   az_addr_q;
    logic [SDRAM_DQ_W-1:0]      az_data_q;

    logic full;
    logic rd_eligible;
    logic accepted;
    logic rsp_window;
    logic rsp_take;
    logic rsp_last;

    function automatic logic [SDRAM_DQ_W-1:0] pad_hi(input logic [HI_W-1:0] hi);
        return SDRAM_DQ_W'(hi);
    endfunction

    assign full        = (level_q == LEVEL_FULL);
    assign rd_eligible = (level_q != '0) && !out_valid_q;
    assign accepted    = az_cs_q && !za_waitrequest;

    // A pending read wins over a new write when the previous grant was a write.
    assign in_ready = reset_n && (state_q == ST_IDLE) && !full &&
                      !(rd_eligible && (last_grant_q == GRANT_WRITE));

    // Responses can land while RD_HI is still stalled, so count from RD_LO on.
    assign rsp_window = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) ||
                        (state_q == ST_RD_WAIT);
    assign rsp_take   = za_valid && rsp_window && (rsp_cnt_q != 2'd2);
    assign rsp_last   = rsp_take && (rsp_cnt_q == 2'd1);

    always_ff @(posedge clk_main) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_READ;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rsp_cnt_q    <= '0;
            wr_hi_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            az_cs_q      <= 1'b0;
            az_rd_n_q    <= 1'b1;
            az_wr_n_q    <= 1'b1;
            az_be_n_q    <= 2'b11;
            az_addr_q    <= '0;
            az_data_q    <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (rsp_take) begin
                rsp_cnt_q <= rsp_cnt_q + 2'd1;
                if (rsp_cnt_q == 2'd0) begin
                    out_data_q[SDRAM_DQ_W-1:0] <= za_data;
                end else begin
                    out_data_q[IQ_PAIR_WIDTH-1:SDRAM_DQ_W] <= za_data[HI_W-1:0];
                    out_valid_q <= 1'b1;
                    rd_ptr_q    <= rd_ptr_q + 1'b1;
                    level_q     <= level_q - 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        last_grant_q <= GRANT_WRITE;
                        wr_hi_q      <= pad_hi(in_data[IQ_PAIR_WIDTH-1:SDRAM_DQ_W]);
                        az_cs_q      <= 1'b1;
                        az_wr_n_q    <= 1'b0;
                        az_be_n_q    <= 2'b00;
                        az_addr_q    <= {wr_ptr_q, 1'b0};
                        az_data_q    <= in_data[SDRAM_DQ_W-1:0];
                        state_q      <= ST_WR_LO;
                    end else if (rd_eligible) begin
                        last_grant_q <= GRANT_READ;
                        rsp_cnt_q    <= '0;
                        az_cs_q      <= 1'b1;
                        az_rd_n_q    <= 1'b0;
                        az_be_n_q    <= 2'b00;
                        az_addr_q    <= {rd_ptr_q, 1'b0};
                        state_q      <= ST_RD_LO;
                    end
                end
                ST_WR_LO: begin
                    if (accepted) begin
                        az_addr_q <= {wr_ptr_q, 1'b1};
                        az_data_q <= wr_hi_q;
                        state_q   <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (accepted) begin
                        az_cs_q   <= 1'b0;
                        az_wr_n_q <= 1'b1;
                        az_be_n_q <= 2'b11;
                        wr_ptr_q  <= wr_ptr_q + 1'b1;
                        level_q   <= level_q + 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RD_LO: begin
                    if (accepted) begin
                        az_addr_q <= {rd_ptr_q, 1'b1};
                        state_q   <= ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    if (accepted) begin
                        az_cs_q   <= 1'b0;
                        az_rd_n_q <= 1'b1;
                        az_be_n_q <= 2'b11;
                        state_q   <= ((rsp_cnt_q == 2'd2) || rsp_last) ? ST_IDLE : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rsp_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (HI_W < SDRAM_DQ_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = |za_data[SDRAM_DQ_W-1:HI_W];
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign az_addr   = az_addr_q;
    assign az_be_n   = az_be_n_q;
    assign az_cs     = az_cs_q;
    assign az_rd_n   = az_rd_n_q;
    assign az_wr_n   = az_wr_n_q;
    assign az_data   = az_data_q;
    assign level     = level_q;

endmodule
